// File: rtl/conv_window_feeder.sv
// Sliding-window feeder: streams one channel into a circular K-row line buffer and
// emits K*K window beats plus one bias beat per output row to the PE array.
module conv_window_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int K = 3,
    parameter int ARRAY_SIZE = IMG_W - K + 1,
    parameter int ADDR_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] BIAS_WORD = 32'h3F80_0000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    output logic [ADDR_WIDTH-1:0]            rd_addr,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_bias,
    output logic                             busy,
    output logic                             done
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int K_W   = (K > 1) ? $clog2(K) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - K);
    localparam logic [K_W:0]     K_EXT    = (K_W + 1)'(K);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRELOAD,
        S_SHIFT,
        S_BIAS,
        S_LOAD
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [K_W-1:0]        r_q, r_d;
    logic [K_W-1:0]        c_q, c_d;
    logic [K_W-1:0]        top_q, top_d;
    logic [ROW_W-1:0]      out_row_q, out_row_d;
    logic                  done_q, done_d;

    logic [DATA_WIDTH-1:0] line_q [K][IMG_W];

    logic                  accept_in;
    logic                  wr_en;
    logic [K_W-1:0]        wr_slot;
    logic [K_W:0]          slot_sum;
    logic [K_W-1:0]        rd_slot;
    logic [COL_W-1:0]      src_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rd_addr_q <= '0;
            col_q     <= '0;
            r_q       <= '0;
            c_q       <= '0;
            top_q     <= '0;
            out_row_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            col_q     <= col_d;
            r_q       <= r_d;
            c_q       <= c_d;
            top_q     <= top_d;
            out_row_q <= out_row_d;
            done_q    <= done_d;
        end
    end

    // PRELOAD fills slots in order using r_q as the slot index; LOAD overwrites the oldest slot.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_q[wr_slot][col_q] <= in_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        col_d     = col_q;
        r_d       = r_q;
        c_d       = c_q;
        top_d     = top_q;
        out_row_d = out_row_q;
        done_d    = 1'b0;

        in_ready  = (state_q == S_PRELOAD) || (state_q == S_LOAD);
        out_valid = (state_q == S_SHIFT) || (state_q == S_BIAS);
        out_bias  = (state_q == S_BIAS);
        busy      = (state_q != S_IDLE);
        accept_in = in_valid && in_ready;
        wr_en     = accept_in;
        wr_slot   = (state_q == S_PRELOAD) ? r_q : top_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_PRELOAD;
                    rd_addr_d = base_addr;
                    out_row_d = '0;
                    top_d     = '0;
                    col_d     = '0;
                    r_d       = '0;
                    c_d       = '0;
                end
            end
            S_PRELOAD: begin
                if (accept_in) begin
                    rd_addr_d = rd_addr_q + 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (r_q == K_LAST) begin
                            r_d     = '0;
                            state_d = S_SHIFT;
                        end else begin
                            r_d = r_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (out_ready) begin
                    if (c_q == K_LAST) begin
                        c_d = '0;
                        if (r_q == K_LAST) begin
                            r_d     = '0;
                            state_d = S_BIAS;
                        end else begin
                            r_d = r_q + 1'b1;
                        end
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
            end
            S_BIAS: begin
                if (out_ready) begin
                    if (out_row_q == ROW_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        out_row_d = out_row_q + 1'b1;
                        state_d   = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (accept_in) begin
                    rd_addr_d = rd_addr_q + 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        top_d   = (top_q == K_LAST) ? '0 : top_q + 1'b1;
                        state_d = S_SHIFT;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Window row r lives in slot (top + r) mod K; top always points at the oldest row.
    always_comb begin
        slot_sum = {1'b0, top_q} + {1'b0, r_q};
        if (slot_sum >= K_EXT) begin
            slot_sum = slot_sum - K_EXT;
        end
        rd_slot  = slot_sum[K_W-1:0];
        src_col  = '0;
        out_data = '0;
        if (state_q == S_SHIFT) begin
            for (int unsigned i = 0; i < ARRAY_SIZE; i++) begin
                src_col = COL_W'(i) + COL_W'(c_q);
                out_data[i*DATA_WIDTH +: DATA_WIDTH] = line_q[rd_slot][src_col];
            end
        end else if (state_q == S_BIAS) begin
            for (int unsigned i = 0; i < ARRAY_SIZE; i++) begin
                out_data[i*DATA_WIDTH +: DATA_WIDTH] = BIAS_WORD;
            end
        end
    end

    assign rd_addr = rd_addr_q;
    assign done    = done_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: image-coordinate reference model, spot-check table,
// stall/gap/restart/reset sequences and randomized handshakes.
module tb_conv_window_feeder;

    localparam int DW = 32;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int KK = 3;
    localparam int AS = W - KK + 1;
    localparam int AW = 16;
    localparam int NB = (H - KK + 1) * (KK * KK + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [AW-1:0]   base_addr = '0;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   in_data;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [AS*DW-1:0] out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_bias;
    logic            busy;
    logic            done;

    logic [AW-1:0]   mem_base = '0;
    logic [AW-1:0]   mem_off;
    int              errors = 0;
    int              checks = 0;

    logic [AS*DW-1:0] cap_data [NB];
    logic             cap_bias [NB];
    logic [AS*DW-1:0] ref_data [NB];

    typedef struct {
        int               beat;
        logic [AS*DW-1:0] data;
        logic             bias;
    } vec_t;
    vec_t tbl [8];

    // External memory: word at base+n holds n.
    assign mem_off = rd_addr - mem_base;
    assign in_data = {16'h0000, mem_off};

    conv_window_feeder #(
        .DATA_WIDTH(DW),
        .IMG_W(W),
        .IMG_H(H),
        .K(KK),
        .ARRAY_SIZE(AS),
        .ADDR_WIDTH(AW),
        .BIAS_WORD(32'h3F80_0000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .base_addr(base_addr),
        .rd_addr(rd_addr),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bias(out_bias),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [AS*DW-1:0] lanes(input int s);
        logic [AS*DW-1:0] v;
        for (int i = 0; i < AS; i++) v[i*DW +: DW] = 32'(s + i);
        return v;
    endfunction

    function automatic logic [AS*DW-1:0] bias_lanes();
        logic [AS*DW-1:0] v;
        for (int i = 0; i < AS; i++) v[i*DW +: DW] = 32'h3F80_0000;
        return v;
    endfunction

    // Beat idx of a frame in image terms: output row y, window row r, column offset c.
    function automatic logic [AS*DW-1:0] exp_data(input int idx);
        int y = idx / (KK * KK + 1);
        int b = idx % (KK * KK + 1);
        if (b == KK * KK) return bias_lanes();
        return lanes((y + b / KK) * W + b % KK);
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_bias"}, out_bias, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic run_frame(input logic [AW-1:0] base, input int pv, input int pr,
                             input bit send_start, input bit inject_start,
                             input bit restart_at_done, input logic [AW-1:0] next_base,
                             input int abort_at);
        int beat = 0;
        int acc = 0;
        int dn = 0;
        int cyc = 0;
        int post = 0;
        bit stall = 1'b0;
        bit seen = 1'b0;
        logic [AS*DW-1:0] hold = '0;
        logic [AW-1:0] end_addr = base + 16'd64;
        if (send_start) begin
            start = 1'b1;
            base_addr = base;
            mem_base = base;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        while (cyc < 4000) begin
            start = 1'b0;
            in_valid = ($urandom_range(99) < pv);
            out_ready = ($urandom_range(99) < pr);
            if (stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, hold);
            end
            if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    chk("preload_accepts", acc, KK * W);
                end
                if (abort_at > 0 && beat == abort_at) return;
                stall = !out_ready;
                hold = out_data;
                if (out_ready) begin
                    if (beat < NB) begin
                        chk("beat_data", out_data, exp_data(beat));
                        chk("beat_bias", out_bias, ((beat % (KK * KK + 1)) == KK * KK));
                        cap_data[beat] = out_data;
                        cap_bias[beat] = out_bias;
                    end else begin
                        chk("extra_beat", beat + 1, NB);
                    end
                    beat++;
                end
            end else begin
                stall = 1'b0;
                chk("idle_data", out_data, 0);
            end
            if (in_valid && in_ready) acc++;
            if (inject_start && beat == 15) begin
                start = 1'b1;
                base_addr = 16'h0BAD;
            end
            if (done) begin
                dn++;
                if (dn == 1) begin
                    chk("end_rd_addr", rd_addr, end_addr);
                    chk("beats_at_done", beat, NB);
                    chk("accepts_at_done", acc, W * H);
                    chk("busy_at_done", busy, 0);
                    if (restart_at_done) begin
                        start = 1'b1;
                        base_addr = next_base;
                        mem_base = next_base;
                        @(posedge clk);
                        #1;
                        start = 1'b0;
                        chk("restart_busy", busy, 1);
                        return;
                    end
                end
            end
            if (dn > 0) begin
                post++;
                if (post > 3) break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("done_count", dn, 1);
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        tbl[0] = '{0,  lanes(0),     1'b0};
        tbl[1] = '{1,  lanes(1),     1'b0};
        tbl[2] = '{8,  lanes(18),    1'b0};
        tbl[3] = '{9,  bias_lanes(), 1'b1};
        tbl[4] = '{10, lanes(8),     1'b0};
        tbl[5] = '{36, lanes(40),    1'b0};
        tbl[6] = '{58, lanes(58),    1'b0};
        tbl[7] = '{59, bias_lanes(), 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Free-flowing frame, then spot checks of named beats
        run_frame(16'h0100, 100, 100, 1'b1, 1'b0, 1'b0, 16'h0, 0);
        for (int i = 0; i < NB; i++) ref_data[i] = cap_data[i];
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tbl_data_b%0d", tbl[i].beat), cap_data[tbl[i].beat], tbl[i].data);
            chk($sformatf("tbl_bias_b%0d", tbl[i].beat), cap_bias[tbl[i].beat], tbl[i].bias);
        end

        // Back-pressure, then input gaps
        run_frame(16'h0100, 100, 50, 1'b1, 1'b0, 1'b0, 16'h0, 0);
        run_frame(16'h0100, 60, 100, 1'b1, 1'b0, 1'b0, 16'h0, 0);

        // Start mid-frame ignored; start in the done cycle restarts
        run_frame(16'h0200, 100, 100, 1'b1, 1'b1, 1'b1, 16'h0300, 0);
        run_frame(16'h0300, 100, 100, 1'b0, 1'b0, 1'b0, 16'h0, 0);

        // Asynchronous reset during SHIFT, then a clean rerun
        run_frame(16'h0100, 100, 100, 1'b1, 1'b0, 1'b0, 16'h0, 4);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_idle", busy, 0);
        run_frame(16'h0100, 100, 100, 1'b1, 1'b0, 1'b0, 16'h0, 0);
        for (int i = 0; i < NB; i++) chk($sformatf("reproduce_b%0d", i), cap_data[i], ref_data[i]);

        // Randomized handshakes, including an address-wrapping base
        for (int n = 0; n < 4; n++) begin
            logic [AW-1:0] b;
            b = (n == 0) ? 16'hFFE0 : AW'($urandom);
            run_frame(b, int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                      1'b1, 1'b0, 1'b0, 16'h0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
